// File: rtl/parallel_in_parallel_out_shift_register.sv
// Parallel-in/parallel-out holding register: captures parallel_in on a load edge,
// holds it otherwise, and drives the stored word straight from the flops.
module parallel_in_parallel_out_shift_register #(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [INPUT_WIDTH-1:0] parallel_in,
  output logic [INPUT_WIDTH-1:0] parallel_out
);

  // Reset wins over load; without load the word is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out <= '0;
    end else if (load) begin
      parallel_out <= parallel_in;
    end
  end

endmodule

// File: tb/tb_parallel_in_parallel_out_shift_register.sv
// Directed bench for the PIPO register: default 8-bit instance plus a 16-bit instance.
module tb_parallel_in_parallel_out_shift_register;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  parallel_in;
  logic [7:0]  parallel_out;

  logic        reset16;
  logic        load16;
  logic [15:0] parallel_in16;
  logic [15:0] parallel_out16;

  int checks;
  int failures;

  parallel_in_parallel_out_shift_register #(.INPUT_WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out)
  );

  parallel_in_parallel_out_shift_register #(.INPUT_WIDTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset16),
    .load         (load16),
    .parallel_in  (parallel_in16),
    .parallel_out (parallel_out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] walk;
    checks   = 0;
    failures = 0;

    // Reset pulse at time 0 with load unknown; no clock edge has happened yet.
    reset         = 1'b1;
    load          = 1'bx;
    parallel_in   = 8'h00;
    reset16       = 1'b1;
    load16        = 1'b0;
    parallel_in16 = 16'h0000;
    #1;
    check("reset_t0", 16'(parallel_out), 16'h0000);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("reset_pulse", 16'(parallel_out), 16'h0000);
    check("reset16_t0", parallel_out16, 16'h0000);

    // Capture.
    @(negedge clk);
    reset       = 1'b0;
    load        = 1'b1;
    parallel_in = 8'b10101101;
    edge_sample();
    check("capture_ad", 16'(parallel_out), 16'h00AD);

    // Back-to-back overwrite.
    @(negedge clk);
    parallel_in = 8'b01011010;
    edge_sample();
    check("overwrite_5a", 16'(parallel_out), 16'h005A);

    // Hold for three edges with a different word on the input.
    @(negedge clk);
    load        = 1'b0;
    parallel_in = 8'b11110000;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("hold_%0d", i), 16'(parallel_out), 16'h005A);
    end

    // Walking one confirms bit i maps to bit i.
    walk = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load        = 1'b1;
      parallel_in = walk;
      edge_sample();
      check($sformatf("walk_%0d", i), 16'(parallel_out), 16'(walk));
      walk = walk << 1;
    end

    // Mid-operation reset with load high: clears at once, holds zero across edges.
    @(negedge clk);
    parallel_in = 8'hA5;
    edge_sample();
    check("preload_a5", 16'(parallel_out), 16'h00A5);
    @(negedge clk);
    #2;
    parallel_in = 8'hFF;
    reset       = 1'b1;
    #1;
    check("async_clear", 16'(parallel_out), 16'h0000);
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      check($sformatf("reset_held_%0d", i), 16'(parallel_out), 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_no_edge", 16'(parallel_out), 16'h0000);
    edge_sample();
    check("first_load_ff", 16'(parallel_out), 16'h00FF);
    @(negedge clk);
    load        = 1'b0;
    parallel_in = 8'h3C;
    edge_sample();
    check("hold_ff", 16'(parallel_out), 16'h00FF);

    // 16-bit instance: no truncation or reversal.
    @(negedge clk);
    reset16       = 1'b0;
    load16        = 1'b1;
    parallel_in16 = 16'hBEEF;
    edge_sample();
    check("w16_beef", parallel_out16, 16'hBEEF);
    @(negedge clk);
    load16        = 1'b0;
    parallel_in16 = 16'h1234;
    edge_sample();
    check("w16_hold", parallel_out16, 16'hBEEF);
    @(negedge clk);
    load16        = 1'b1;
    parallel_in16 = 16'h8001;
    edge_sample();
    check("w16_ends", parallel_out16, 16'h8001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
